sram_data_controller: RTL

Responder side of the MEM-stage data-memory interface. Accepts 32-bit word read/write requests from the memory stage (ALU result as address, Rm value as write data) and performs them on a 16-bit external SRAM as two half-word bus cycles. While an access is in flight it holds `ready` low so the pipeline freezes; `ready` rises for exactly one cycle when read data is valid or the write has completed.

---
 rtl/sram_data_controller.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sram_data_controller.sv
// MEM-stage data-memory responder: each 32-bit word access becomes two 16-bit
// SRAM bus phases (low half, then high half) while ready stalls the pipeline.
module sram_data_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        op_write;
  logic [16:0] widx;
  logic [31:0] wdata;
  logic        req;
  logic        phase_end;
  logic [31:0] offset;
  logic        dq_drive;
  logic [15:0] dq_out;
  logic        unused_offset_bits;

  assign req       = mem_read | mem_write;
  assign phase_end = (cnt == LAST);
  assign offset    = address - 32'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Request fields are captured on acceptance so mid-access input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      widx      <= '0;
      wdata     <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        op_write <= mem_write;
        widx     <= offset[18:2];
        wdata    <= write_data;
      end
      if (state == LOW && phase_end && !op_write)
        read_data[15:0] <= SRAM_DQ;
      if (state == HIGH && phase_end && !op_write)
        read_data[31:16] <= SRAM_DQ;
    end
  end

  // Bus strobes depend only on state and latched fields, never on live req.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_drive  = 1'b0;
    dq_out    = '0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        SRAM_ADDR = {widx, 1'b0};
        SRAM_WE_N = ~op_write;
        SRAM_OE_N = op_write;
        dq_drive  = op_write;
        dq_out    = wdata[15:0];
        if (phase_end) begin
          cnt_nxt   = '0;
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      HIGH: begin
        SRAM_ADDR = {widx, 1'b1};
        SRAM_WE_N = ~op_write;
        SRAM_OE_N = op_write;
        dq_drive  = op_write;
        dq_out    = wdata[31:16];
        if (phase_end) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign SRAM_DQ = dq_drive ? dq_out : 16'hzzzz;

endmodule
